// File: rtl/osd_text_writer.sv
// On-screen-display text writer: turns CLEAR / PUTC / HEX commands into
// one-cell-per-cycle character RAM writes.
module osd_text_writer #(
    parameter int unsigned COLS          = 40,
    parameter int unsigned ROWS          = 30,
    parameter int unsigned CHAR_RAM_SIZE = COLS * ROWS
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [5:0]  cmd_col,
    input  logic [4:0]  cmd_row,
    input  logic [15:0] cmd_data,
    input  logic [2:0]  cmd_len,
    output logic [10:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        wr_en,
    output logic        busy,
    output logic        cmd_err
);

    localparam int unsigned COL_W  = 6;
    localparam int unsigned ROW_W  = 5;
    localparam int unsigned ADDR_W = 11;

    localparam logic [COL_W-1:0]  COLS_LIM  = COL_W'(COLS);
    localparam logic [ROW_W-1:0]  ROWS_LIM  = ROW_W'(ROWS);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(CHAR_RAM_SIZE - 1);

    // State encoding matches cmd_op so an accepted command maps directly.
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_PUTC  = 2'd1,
        ST_HEX   = 2'd2,
        ST_IDLE  = 2'd3
    } state_t;

    state_t              state, state_n;
    logic [COL_W-1:0]    col_q, col_n;
    logic [ROW_W-1:0]    row_q, row_n;
    logic [15:0]         data_q, data_n;
    logic [2:0]          left_q, left_n;
    logic [ADDR_W-1:0]   clr_q, clr_n;

    logic                cmd_ready_n, wr_en_n, busy_n, cmd_err_n;
    logic [ADDR_W-1:0]   wr_addr_n;
    logic [7:0]          wr_data_n;

    logic                cmd_ok;
    logic [ADDR_W-1:0]   cell_addr;
    logic [3:0]          nib;
    logic [7:0]          hex_char;

    // Command legality check, evaluated on the offered fields.
    always_comb begin
        cmd_ok = 1'b0;
        case (cmd_op)
            2'd0: cmd_ok = 1'b1;
            2'd1: cmd_ok = (cmd_col < COLS_LIM) && (cmd_row < ROWS_LIM);
            2'd2: cmd_ok = (cmd_col < COLS_LIM) && (cmd_row < ROWS_LIM) &&
                           (cmd_len != 3'd0) && (cmd_len <= 3'd4);
            default: cmd_ok = 1'b0;
        endcase
    end

    assign cell_addr = {6'b0, row_q} * COLS_A + {5'b0, col_q};
    assign nib       = 4'(data_q >> {left_q - 3'd1, 2'b00});
    assign hex_char  = (nib < 4'd10) ? (8'h30 + {4'b0, nib}) : (8'h37 + {4'b0, nib});

    // Next-state and registered-output computation.
    always_comb begin
        state_n     = state;
        col_n       = col_q;
        row_n       = row_q;
        data_n      = data_q;
        left_n      = left_q;
        clr_n       = clr_q;
        wr_en_n     = 1'b0;
        wr_addr_n   = wr_addr;
        wr_data_n   = wr_data;
        cmd_err_n   = 1'b0;
        cmd_ready_n = 1'b0;

        case (state)
            ST_IDLE: begin
                cmd_ready_n = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    if (cmd_ok) begin
                        cmd_ready_n = 1'b0;
                        state_n     = state_t'(cmd_op);
                        col_n       = cmd_col;
                        row_n       = cmd_row;
                        data_n      = cmd_data;
                        left_n      = cmd_len;
                        clr_n       = '0;
                    end else begin
                        cmd_err_n = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                wr_en_n   = 1'b1;
                wr_addr_n = clr_q;
                wr_data_n = data_q[7:0];
                clr_n     = clr_q + ADDR_W'(1);
                if (clr_q == CLR_LAST) state_n = ST_IDLE;
            end
            ST_PUTC: begin
                wr_en_n   = 1'b1;
                wr_addr_n = cell_addr;
                wr_data_n = data_q[7:0];
                state_n   = ST_IDLE;
            end
            ST_HEX: begin
                wr_en_n   = 1'b1;
                wr_addr_n = cell_addr;
                wr_data_n = hex_char;
                left_n    = left_q - 3'd1;
                if (col_q == COL_LAST) begin
                    col_n = '0;
                    row_n = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_n = col_q + COL_W'(1);
                end
                if (left_q == 3'd1) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        // Busy covers the final write cycle as well as the active states.
        busy_n = (state_n != ST_IDLE) || wr_en_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            data_q    <= '0;
            left_q    <= '0;
            clr_q     <= '0;
            cmd_ready <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state     <= state_n;
            col_q     <= col_n;
            row_q     <= row_n;
            data_q    <= data_n;
            left_q    <= left_n;
            clr_q     <= clr_n;
            cmd_ready <= cmd_ready_n;
            wr_en     <= wr_en_n;
            wr_addr   <= wr_addr_n;
            wr_data   <= wr_data_n;
            busy      <= busy_n;
            cmd_err   <= cmd_err_n;
        end
    end

endmodule

// File: tb/tb_osd_text_writer.sv
// Bench for osd_text_writer: command table plus scoreboard of expected RAM
// writes, with hand-built CLEAR and mid-command reset sequences.
module tb_osd_text_writer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [5:0]  cmd_col;
    logic [4:0]  cmd_row;
    logic [15:0] cmd_data;
    logic [2:0]  cmd_len;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        busy;
    logic        cmd_err;

    osd_text_writer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_col   (cmd_col),
        .cmd_row   (cmd_row),
        .cmd_data  (cmd_data),
        .cmd_len   (cmd_len),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .busy      (busy),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       op;
        logic [5:0]       col;
        logic [4:0]       row;
        logic [15:0]      data;
        logic [2:0]       len;
        logic             err;
        logic [2:0]       n;
        logic [3:0][10:0] a;
        logic [3:0][7:0]  d;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [18:0] exp_q[$];
    vec_t        vecs[14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [5:0] col, input logic [4:0] row,
                                input logic [15:0] data, input logic [2:0] len, input logic err,
                                input logic [2:0] n,
                                input logic [10:0] a0, input logic [7:0] d0,
                                input logic [10:0] a1, input logic [7:0] d1,
                                input logic [10:0] a2, input logic [7:0] d2,
                                input logic [10:0] a3, input logic [7:0] d3);
        vec_t v;
        v.op = op; v.col = col; v.row = row; v.data = data; v.len = len;
        v.err = err; v.n = n;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        return v;
    endfunction

    // Scoreboard: every write the DUT makes must match the head of the queue.
    always @(negedge clk) begin
        if (reset_n && wr_en) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL stray_write: got addr %0d data %02h, expected no write", wr_addr, wr_data);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                check("write_addr_data", 32'({wr_addr, wr_data}), 32'(e));
                if (!busy) check("busy_during_write", 32'(busy), 32'd1);
            end
        end
    end

    task automatic drain(input int limit);
        int b = 0;
        while (exp_q.size() != 0 && b < limit) begin
            @(posedge clk); #1;
            b++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout_remaining", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    // Called at posedge+1; drives one command and checks the handshake around it.
    task automatic send(input logic [1:0] op, input logic [5:0] col, input logic [4:0] row,
                        input logic [15:0] data, input logic [2:0] len, input logic err);
        int b = 0;
        cmd_op = op; cmd_col = col; cmd_row = row; cmd_data = data; cmd_len = len;
        cmd_valid = 1'b1;
        while (!cmd_ready && b < 3000) begin
            @(posedge clk); #1;
            b++;
        end
        if (!cmd_ready) begin
            check("ready_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("cmd_err_after_accept", 32'(cmd_err), 32'(err));
        check("no_write_on_accept_cycle", 32'(wr_en), 32'd0);
        if (err) begin
            check("ready_held_on_reject", 32'(cmd_ready), 32'd1);
            @(posedge clk); #1;
            check("cmd_err_single_pulse", 32'(cmd_err), 32'd0);
            check("ready_after_reject", 32'(cmd_ready), 32'd1);
        end else begin
            @(posedge clk); #1;
            check("first_write_latency", 32'(wr_en), 32'd1);
            drain(3000);
            check("ready_after_last_write", 32'(cmd_ready), 32'd1);
            check("idle_wr_en_low", 32'(wr_en), 32'd0);
            check("idle_busy_low", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0;
        cmd_op = '0; cmd_col = '0; cmd_row = '0; cmd_data = '0; cmd_len = '0;

        vecs[0]  = mk(2'd1, 6'd5,  5'd2,  16'h0041, 3'd0, 1'b0, 3'd1, 11'd85,   8'h41, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(2'd2, 6'd38, 5'd0,  16'hBEEF, 3'd4, 1'b0, 3'd4, 11'd38,   8'h42, 11'd39, 8'h45, 11'd40, 8'h45, 11'd41, 8'h46);
        vecs[2]  = mk(2'd2, 6'd39, 5'd29, 16'h00A7, 3'd2, 1'b0, 3'd2, 11'd1199, 8'h41, 11'd0, 8'h37, 0, 0, 0, 0);
        vecs[3]  = mk(2'd1, 6'd40, 5'd0,  16'h0041, 3'd0, 1'b1, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(2'd2, 6'd0,  5'd0,  16'h1234, 3'd0, 1'b1, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(2'd3, 6'd0,  5'd0,  16'h0041, 3'd1, 1'b1, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[6]  = mk(2'd2, 6'd0,  5'd30, 16'h0001, 3'd1, 1'b1, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[7]  = mk(2'd2, 6'd0,  5'd0,  16'h0001, 3'd5, 1'b1, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[8]  = mk(2'd1, 6'd0,  5'd31, 16'h0041, 3'd0, 1'b1, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[9]  = mk(2'd2, 6'd0,  5'd0,  16'h0009, 3'd1, 1'b0, 3'd1, 11'd0,    8'h39, 0, 0, 0, 0, 0, 0);
        vecs[10] = mk(2'd2, 6'd10, 5'd1,  16'h1234, 3'd3, 1'b0, 3'd3, 11'd50,   8'h32, 11'd51, 8'h33, 11'd52, 8'h34, 0, 0);
        vecs[11] = mk(2'd1, 6'd39, 5'd29, 16'h007E, 3'd0, 1'b0, 3'd1, 11'd1199, 8'h7E, 0, 0, 0, 0, 0, 0);
        vecs[12] = mk(2'd2, 6'd39, 5'd0,  16'h00CD, 3'd2, 1'b0, 3'd2, 11'd39,   8'h43, 11'd40, 8'h44, 0, 0, 0, 0);
        vecs[13] = mk(2'd2, 6'd0,  5'd3,  16'h0F1A, 3'd4, 1'b0, 3'd4, 11'd120,  8'h30, 11'd121, 8'h46, 11'd122, 8'h31, 11'd123, 8'h41);

        @(posedge clk); #1;
        check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        check("reset_wr_en", 32'(wr_en), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_wr_addr", 32'(wr_addr), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        check("ready_first_edge_after_reset", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 14; i++) begin
            if (!vecs[i].err)
                for (int k = 0; k < int'(vecs[i].n); k++)
                    exp_q.push_back({vecs[i].a[k], vecs[i].d[k]});
            send(vecs[i].op, vecs[i].col, vecs[i].row, vecs[i].data, vecs[i].len, vecs[i].err);
        end

        // Full-screen CLEAR; col/row/len are junk and must be ignored.
        for (int k = 0; k < 1200; k++) exp_q.push_back({11'(k), 8'h20});
        send(2'd0, 6'd63, 5'd31, 16'hFF20, 3'd7, 1'b0);

        // CLEAR interrupted by reset right after the write to address 300.
        for (int k = 0; k <= 300; k++) exp_q.push_back({11'(k), 8'h2E});
        cmd_op = 2'd0; cmd_data = 16'h002E; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        begin
            int b = 0;
            while (exp_q.size() != 0 && b < 2000) begin
                @(negedge clk); #1;
                b++;
            end
        end
        check("reached_addr_300", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        reset_n = 1'b0;
        #1;
        check("async_reset_wr_en", 32'(wr_en), 32'd0);
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_ready", 32'(cmd_ready), 32'd0);
        check("async_reset_addr", 32'(wr_addr), 32'd0);
        check("async_reset_data", 32'(wr_data), 32'd0);
        check("async_reset_err", 32'(cmd_err), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("ready_after_abort_release", 32'(cmd_ready), 32'd1);
        exp_q.push_back({11'd85, 8'h41});
        send(2'd1, 6'd5, 5'd2, 16'h0041, 3'd0, 1'b0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
